period_pulse_gen: RTL

Programmable periodic waveform generator: produces a registered square or pulse wave whose period and high time, counted in `clk` cycles, are loaded through a valid/ready config port. Where the assertion-based period monitors measure the distance between clock edges, this block generates edges at a programmed distance. It drives those monitors' stimulus and feeds timer/strobe consumers in the design. New settings take effect only on period boundaries, so the output never shows a truncated or glitched period.

---
 rtl/period_pulse_gen_if.sv | 24 ++
 rtl/period_pulse_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/period_pulse_gen_if.sv
// Config/run/output bundle for period_pulse_gen; slave side is the generator.
interface period_pulse_gen_if #(
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             en;
  logic             wave_out;
  logic             tick;
  logic             busy;
  logic             err;

  modport master (
    output cfg_valid, cfg_period, cfg_high, en,
    input  cfg_ready, wave_out, tick, busy, err
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_high, en,
    output cfg_ready, wave_out, tick, busy, err
  );
endinterface

// File: rtl/period_pulse_gen.sv
// Registered periodic wave/tick generator; en->first tick 2 cycles, cfg_ready low while a shadow config waits for a period boundary.
// Optional edge-to-edge period self-check enabled by PGEN_PERIOD_CHECK_EN (err tied 0 otherwise).
module period_pulse_gen #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  period_pulse_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state;
  logic [CNT_W-1:0] per_a, high_a, per_s, high_s, ph;
  logic             pend, wave_q, tick_q;
  logic             active, wrap, accept;
  logic [CNT_W-1:0] per_clamp, high_clamp;

  assign active = (state != IDLE);
  assign wrap   = active && (ph == per_a - ONE);
  assign accept = bus.cfg_valid && !pend;

  always_comb begin
    per_clamp  = (bus.cfg_period < TWO) ? TWO : bus.cfg_period;
    high_clamp = (bus.cfg_high >= per_clamp) ? per_clamp - ONE : bus.cfg_high;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ph     <= '0;
      per_a  <= '0;
      high_a <= '0;
      per_s  <= '0;
      high_s <= '0;
      pend   <= 1'b0;
      wave_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= active && (ph == '0);
      wave_q <= active && (ph < high_a);
      case (state)
        IDLE: begin
          ph <= '0;
          if (bus.en && (per_a != '0)) state <= RUN;
        end
        RUN: begin
          ph <= wrap ? '0 : ph + ONE;
          // en dropping on the last cycle of a period stops right there
          if (!bus.en) state <= wrap ? IDLE : STOPPING;
        end
        STOPPING: begin
          ph <= wrap ? '0 : ph + ONE;
          if (bus.en)    state <= RUN;
          else if (wrap) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ph    <= '0;
        end
      endcase
      // accept needs !pend and copy needs pend, so they never collide
      if (pend && (!active || wrap)) begin
        per_a  <= per_s;
        high_a <= high_s;
        pend   <= 1'b0;
      end else if (accept) begin
        per_s  <= per_clamp;
        high_s <= high_clamp;
        pend   <= 1'b1;
      end
    end
  end

  assign bus.cfg_ready = !pend;
  assign bus.wave_out  = wave_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = active;

`ifdef PGEN_PERIOD_CHECK_EN
  logic [CNT_W-1:0] per_tag, chk_per, chk_cnt;
  logic             hi_tag, out_busy, wave_d, chk_arm, err_q, chk_evt;

  // per_tag/hi_tag/out_busy are aligned with the registered outputs
  assign chk_evt = hi_tag ? (wave_q && !wave_d) : tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_tag  <= '0;
      hi_tag   <= 1'b0;
      out_busy <= 1'b0;
      wave_d   <= 1'b0;
      chk_per  <= '0;
      chk_cnt  <= '0;
      chk_arm  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      out_busy <= active;
      wave_d   <= wave_q;
      if (active && (ph == '0)) begin
        per_tag <= per_a;
        hi_tag  <= (high_a != '0);
      end
      if (chk_evt) begin
        if (chk_arm && (chk_cnt != chk_per)) err_q <= 1'b1;
        chk_cnt <= ONE;
        chk_per <= per_tag;
        chk_arm <= 1'b1;
      end else begin
        if (chk_cnt != '1) chk_cnt <= chk_cnt + ONE;
        if (!out_busy)     chk_arm <= 1'b0;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule
